// File: rtl/redmule_z_drain_pkg.sv
// Shared widths, FSM encoding and control/flag bundles for the Z drain path.
package redmule_z_drain_pkg;

  localparam int DATA_W      = 320;
  localparam int DATAW       = DATA_W - 64;
  localparam int BITW        = 16;
  localparam int ARRAY_WIDTH = 12;
  localparam int TOT_DEPTH   = DATAW / BITW;
  localparam int STRB        = DATA_W / 8;
  localparam int ZBYTES      = DATAW / 8;
  localparam int ROW_W       = $clog2(ARRAY_WIDTH) + 1;
  localparam int COL_W       = $clog2(TOT_DEPTH) + 1;

  typedef enum logic [1:0] {
    Z_IDLE,
    Z_RUN,
    Z_FLUSH
  } z_drain_state_e;

  typedef struct packed {
    logic [15:0]      n_tiles;
    logic [ROW_W-1:0] rows_lftovr;
    logic [COL_W-1:0] cols_lftovr;
    logic             start;
  } z_drain_ctrl_t;

  typedef struct packed {
    logic stored;
    logic done;
    logic busy;
  } z_drain_flgs_t;

endpackage

// File: rtl/redmule_z_strb_gen.sv
// Column-leftover to byte-strobe mask; purely combinational.
// Upper (non-payload) strobe bytes are never set.
module redmule_z_strb_gen
  import redmule_z_drain_pkg::*;
(
  input  logic [COL_W-1:0] cols_lftovr_i,
  output logic [STRB-1:0]  strb_o
);

  int n_bytes;

  always_comb begin
    n_bytes = ZBYTES;
    if (cols_lftovr_i != '0 && int'(cols_lftovr_i) < TOT_DEPTH)
      n_bytes = int'(cols_lftovr_i) * (BITW / 8);
    strb_o = '0;
    for (int b = 0; b < ZBYTES; b++)
      strb_o[b] = (b < n_bytes);
  end

endmodule

// File: rtl/redmule_z_drain.sv
// Drains Z rows into masked TCDM store beats; 1-cycle latency, single output register.
// Backpressure: a stalled beat is held and row_ready_o drops until the sink takes it.
module redmule_z_drain
  import redmule_z_drain_pkg::*;
(
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [15:0]       n_tiles_i,
  input  logic [ROW_W-1:0]  rows_lftovr_i,
  input  logic [COL_W-1:0]  cols_lftovr_i,
  input  logic [DATAW-1:0]  row_data_i,
  input  logic              row_valid_i,
  output logic              row_ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic [STRB-1:0]   strb_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              stored_o,
  output logic              done_o,
  output logic              busy_o
);

  z_drain_state_e    state_q;
  z_drain_ctrl_t     cfg_q;
  z_drain_flgs_t     flgs_q;
  logic [15:0]       tile_cnt_q;
  logic [ROW_W-1:0]  row_cnt_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB-1:0]   strb_q;
  logic              beat_last_row_q;
  logic              beat_final_q;

  logic [STRB-1:0]   strb_mask;
  logic [ROW_W-1:0]  rows_in_tile;
  logic              last_tile;
  logic              last_row;
  logic              row_hs;
  logic              out_hs;

  redmule_z_strb_gen i_strb_gen (
    .cols_lftovr_i (cfg_q.cols_lftovr),
    .strb_o        (strb_mask)
  );

  assign last_tile    = (tile_cnt_q == cfg_q.n_tiles - 16'd1);
  assign rows_in_tile = (last_tile && cfg_q.rows_lftovr != '0) ? cfg_q.rows_lftovr
                                                                : ROW_W'(ARRAY_WIDTH);
  assign last_row     = (row_cnt_q == rows_in_tile - ROW_W'(1));
  assign row_ready_o  = (state_q == Z_RUN) && cfg_q.start && (!valid_q || ready_i);
  assign row_hs       = row_valid_i && row_ready_o;
  assign out_hs       = valid_q && ready_i;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q         <= Z_IDLE;
      cfg_q           <= '0;
      flgs_q          <= '0;
      tile_cnt_q      <= '0;
      row_cnt_q       <= '0;
      valid_q         <= 1'b0;
      data_q          <= '0;
      strb_q          <= '0;
      beat_last_row_q <= 1'b0;
      beat_final_q    <= 1'b0;
    end else begin
      flgs_q.stored <= 1'b0;
      flgs_q.done   <= 1'b0;

      // Flags follow the handshake of the beat that carries the tile/job tail.
      if (out_hs) begin
        flgs_q.stored <= beat_last_row_q;
        flgs_q.done   <= beat_final_q;
      end

      if (row_hs) begin
        valid_q         <= 1'b1;
        data_q          <= {64'b0, row_data_i};
        strb_q          <= strb_mask;
        beat_last_row_q <= last_row;
        beat_final_q    <= last_row && last_tile;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        Z_IDLE: begin
          if (start_i) begin
            cfg_q      <= '{n_tiles: n_tiles_i, rows_lftovr: rows_lftovr_i,
                            cols_lftovr: cols_lftovr_i, start: 1'b1};
            tile_cnt_q <= '0;
            row_cnt_q  <= '0;
            if (n_tiles_i == 16'd0) begin
              flgs_q.done <= 1'b1;
            end else begin
              state_q     <= Z_RUN;
              flgs_q.busy <= 1'b1;
            end
          end
        end
        Z_RUN: begin
          if (row_hs) begin
            if (last_row) begin
              row_cnt_q  <= '0;
              tile_cnt_q <= tile_cnt_q + 16'd1;
              if (last_tile)
                state_q <= Z_FLUSH;
            end else begin
              row_cnt_q <= row_cnt_q + ROW_W'(1);
            end
          end
        end
        Z_FLUSH: begin
          if (out_hs) begin
            state_q     <= Z_IDLE;
            flgs_q.busy <= 1'b0;
            cfg_q.start <= 1'b0;
          end
        end
        default: state_q <= Z_IDLE;
      endcase
    end
  end

  assign data_o   = data_q;
  assign strb_o   = strb_q;
  assign valid_o  = valid_q;
  assign stored_o = flgs_q.stored;
  assign done_o   = flgs_q.done;
  assign busy_o   = flgs_q.busy;

endmodule
